// File: rtl/alu_pkg.sv
// Shared ALU opcodes, control width, arbiter FSM state type
// and the legal-opcode helper.
package alu_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR  = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL = 4'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(
    input logic [ALU_CTRL_WIDTH-1:0] op
  );
    return (op == OP_AND) || (op == OP_OR)  ||
           (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLL/SRL with flags.
// Ports: ctrl, a, b -> result, zero, overflow, exception.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = alu_pkg::ALU_CTRL_WIDTH
) (
  input  logic [ALU_CTRL_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      zero,
  output logic                      overflow,
  output logic                      exception
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam int MSB  = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [SH_W-1:0]       shamt;
  logic is_and, is_or, is_add;
  logic is_sub, is_sll, is_srl;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  assign is_and = (ctrl == OP_AND);
  assign is_or  = (ctrl == OP_OR);
  assign is_add = (ctrl == OP_ADD);
  assign is_sub = (ctrl == OP_SUB);
  assign is_sll = (ctrl == OP_SLL);
  assign is_srl = (ctrl == OP_SRL);

  // Reserved opcodes yield zero and raise exception.
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    exception = 1'b0;
    unique case (1'b1)
      is_and: result = a & b;
      is_or:  result = a | b;
      is_add: begin
        result   = sum;
        overflow = (a[MSB] == b[MSB]) &&
                   (sum[MSB] != a[MSB]);
      end
      is_sub: begin
        result   = diff;
        overflow = (a[MSB] != b[MSB]) &&
                   (diff[MSB] != a[MSB]);
      end
      is_sll: result = a << shamt;
      is_srl: result = a >> shamt;
      default: exception = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: first request at or after ptr wins.
// Ports: req, ptr -> one-hot grant, idx, any.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// NUM_REQ requesters share one ALU via IDLE/EXEC/RESP FSM.
// Ports: req_valid/ready/ctrl/i_1/i_2 in, resp_valid/ready,
// resp_o + flags out, busy. Optional: ALU_ARB_ILLEGAL_OP_CHK_EN
// turns reserved opcodes into resp_error with zero result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = alu_pkg::ALU_CTRL_WIDTH,
  parameter int NUM_REQ        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ALU_CTRL_WIDTH-1:0] req_ctrl,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_i_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_i_2,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [DATA_WIDTH-1:0]             resp_o,
  output logic                              resp_zero,
  output logic                              resp_overflow,
  output logic                              resp_exception,
  output logic                              resp_error,
  output logic                              busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = ALU_CTRL_WIDTH;
  localparam int DW = DATA_WIDTH;

  state_t state, state_nx;

  logic [IW-1:0]      ptr, idx_q, gnt_idx, ptr_nx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any, take;
  logic [CW-1:0]      ctrl_q;
  logic [DW-1:0]      a_q, b_q;
  logic [DW-1:0]      alu_res, res_q;
  logic alu_z, alu_ov, alu_ex;
  logic z_q, ov_q, ex_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  alu #(
    .DATA_WIDTH     (DW),
    .ALU_CTRL_WIDTH (CW)
  ) u_alu (
    .ctrl      (ctrl_q),
    .a         (a_q),
    .b         (b_q),
    .result    (alu_res),
    .zero      (alu_z),
    .overflow  (alu_ov),
    .exception (alu_ex)
  );

  assign take   = (state == IDLE) && gnt_any && !rst;
  assign ptr_nx = (gnt_idx == IW'(NUM_REQ - 1)) ?
                  '0 : gnt_idx + 1'b1;

  // Handshakes are masked during reset so nothing is
  // accepted or delivered on an aborting edge.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          req_ready = gnt;
          state_nx  = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        resp_valid[idx_q] = !rst;
        if (resp_ready[idx_q]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx_q  <= '0;
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        ptr    <= ptr_nx;
        idx_q  <= gnt_idx;
        ctrl_q <= req_ctrl[gnt_idx*CW +: CW];
        a_q    <= req_i_1[gnt_idx*DW +: DW];
        b_q    <= req_i_2[gnt_idx*DW +: DW];
      end
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      z_q   <= 1'b0;
      ov_q  <= 1'b0;
      ex_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (state == EXEC) begin
      if (!op_is_legal(ctrl_q)) begin
        res_q <= '0;
        z_q   <= 1'b1;
        ov_q  <= 1'b0;
        ex_q  <= 1'b0;
        err_q <= 1'b1;
      end else begin
        res_q <= alu_res;
        z_q   <= alu_z;
        ov_q  <= alu_ov;
        ex_q  <= alu_ex;
        err_q <= 1'b0;
      end
    end
  end

  assign resp_error = err_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      z_q   <= 1'b0;
      ov_q  <= 1'b0;
      ex_q  <= 1'b0;
    end else if (state == EXEC) begin
      res_q <= alu_res;
      z_q   <= alu_z;
      ov_q  <= alu_ov;
      ex_q  <= alu_ex;
    end
  end

  assign resp_error = 1'b0;
`endif

  assign resp_o         = res_q;
  assign resp_zero      = z_q;
  assign resp_overflow  = ov_q;
  assign resp_exception = ex_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table,
// corner sequences and a randomized reference model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int N  = 2;

`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_ctrl;
  logic [N*DW-1:0] req_i_1;
  logic [N*DW-1:0] req_i_2;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_o;
  logic            resp_zero;
  logic            resp_overflow;
  logic            resp_exception;
  logic            resp_error;
  logic            busy;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_WIDTH     (DW),
    .ALU_CTRL_WIDTH (CW),
    .NUM_REQ        (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ctrl       (req_ctrl),
    .req_i_1        (req_i_1),
    .req_i_2        (req_i_2),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_o         (resp_o),
    .resp_zero      (resp_zero),
    .resp_overflow  (resp_overflow),
    .resp_exception (resp_exception),
    .resp_error     (resp_error),
    .busy           (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] r;
    logic z, ov, ex, err;
  } res_t;

  // Reference ALU from signed arithmetic in 64 bits.
  function automatic res_t ref_op(input int ctrl,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    res_t o;
    longint sa, sb, s, mx, mn;
    o  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mx = 2147483647;
    mn = -mx - 1;
    case (ctrl)
      0: o.r = a & b;
      1: o.r = a | b;
      2: begin
        s = sa + sb;
        o.r = a + b;
        o.ov = (s > mx) || (s < mn);
      end
      6: begin
        s = sa - sb;
        o.r = a - b;
        o.ov = (s > mx) || (s < mn);
      end
      8: o.r = a << b[4:0];
      9: o.r = a >> b[4:0];
      default: begin
        o.r = '0;
        if (CHK) o.err = 1'b1;
        else     o.ex  = 1'b1;
      end
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  typedef struct packed {
    int          k;
    int          ctrl;
    logic [31:0] a, b, r;
    logic        z, ov, rsv;
  } vec_t;

  vec_t tbl[10];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input int ctrl,
                         input logic [31:0] a,
                         input logic [31:0] b);
    logic [CW-1:0] c;
    c = CW'(ctrl);
    req_ctrl[k*CW +: CW] = c;
    req_i_1[k*DW +: DW]  = a;
    req_i_2[k*DW +: DW]  = b;
  endtask

  // Waits for any resp_valid within a bounded number of
  // cycles; the caller compares what is seen.
  task automatic wait_resp(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (resp_valid != '0) break;
    end
  endtask

  task automatic wait_grant(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    oh = N'(1) << v.k;
    @(posedge clk); #1;
    set_req(v.k, v.ctrl, v.a, v.b);
    req_valid = oh;
    @(negedge clk);
    chk("vec_grant", req_ready, oh);
    chk("vec_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    req_ctrl = $urandom;
    req_i_1 = {$urandom, $urandom};
    req_i_2 = {$urandom, $urandom};
    @(negedge clk);
    chk("vec_exec_rv", resp_valid, '0);
    chk("vec_exec_busy", busy, 1'b1);
    chk("vec_exec_rdy", req_ready, '0);
    @(negedge clk);
    chk("vec_rv_t2", resp_valid, oh);
    chk("vec_res", resp_o, v.r);
    chk("vec_zero", resp_zero, v.z);
    chk("vec_ovf", resp_overflow, v.ov);
    chk("vec_exc", resp_exception, v.rsv & ~CHK);
    chk("vec_err", resp_error, v.rsv & CHK);
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = '0;
    @(negedge clk);
    chk("vec_back_idle", busy, 1'b0);
    chk("vec_rv_clear", resp_valid, '0);
  endtask

  initial begin
    res_t e;
    logic [N-1:0] exp_oh;
    int   legal[6];

    legal = '{0, 1, 2, 6, 8, 9};

    tbl[0] = '{0, 2, 32'd5, 32'd7, 32'd12,
               1'b0, 1'b0, 1'b0};
    tbl[1] = '{1, 6, 32'd3, 32'd3, 32'd0,
               1'b1, 1'b0, 1'b0};
    tbl[2] = '{0, 2, 32'h7FFF_FFFF, 32'd1,
               32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1, 0, 32'h0000_F0F0, 32'h0000_0FF0,
               32'h0000_00F0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{0, 1, 32'h0000_F000, 32'h0000_000F,
               32'h0000_F00F, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1, 8, 32'd1, 32'd4, 32'h10,
               1'b0, 1'b0, 1'b0};
    tbl[6] = '{0, 9, 32'h8000_0000, 32'd31, 32'd1,
               1'b0, 1'b0, 1'b0};
    tbl[7] = '{1, 6, 32'h8000_0000, 32'd1,
               32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{0, 3, 32'd9, 32'd9, 32'd0,
               1'b1, 1'b0, 1'b1};
    tbl[9] = '{1, 2, 32'hFFFF_FFFF, 32'd1, 32'd0,
               1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid = '1;
    resp_ready = '0;
    req_ctrl = '0;
    req_i_1 = '0;
    req_i_2 = '0;

    // Reset state, with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_resp_o", resp_o, '0);
    chk("rst_flags", {resp_zero, resp_overflow,
                      resp_exception, resp_error}, '0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Table vectors
    foreach (tbl[i]) run_vec(tbl[i]);

    // Alternating grants with both valid
    do_reset();
    set_req(0, 2, 32'd10, 32'd20);
    set_req(1, 6, 32'd100, 32'd1);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(6);
      chk("alt_grant", req_ready, exp_oh);
      wait_resp(6);
      chk("alt_resp_idx", resp_valid, exp_oh);
      chk("alt_resp_o", resp_o,
          (g % 2 == 0) ? 32'd30 : 32'd99);
    end
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = '0;
    wait_resp(3);
    @(posedge clk); #1;

    // Stall in RESP; other requester waits
    do_reset();
    set_req(0, 2, 32'h1234, 32'h1111);
    set_req(1, 0, 32'hFFFF, 32'h00FF);
    req_valid = 2'b01;
    wait_grant(4);
    chk("stall_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    resp_ready = 2'b10;
    wait_resp(4);
    for (int c = 0; c < 5; c++) begin
      chk("stall_rv", resp_valid, 2'b01);
      chk("stall_o", resp_o, 32'h2345);
      chk("stall_rdy", req_ready, '0);
      chk("stall_busy", busy, 1'b1);
      @(negedge clk);
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    @(negedge clk);
    chk("stall_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = 2'b10;
    wait_resp(4);
    chk("stall_r1_rv", resp_valid, 2'b10);
    chk("stall_r1_o", resp_o, 32'h00FF);
    @(posedge clk); #1;
    resp_ready = '0;

    // Reset during EXEC
    do_reset();
    set_req(0, 2, 32'd40, 32'd2);
    req_valid = 2'b01;
    @(negedge clk);
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rv", resp_valid, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_o", resp_o, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_stale", resp_valid, '0);
    end
    @(posedge clk); #1;
    set_req(1, 2, 32'd1, 32'd1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("abort_ptr0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = 2'b11;
    wait_resp(4);
    chk("abort_after_o", resp_o, 32'd42);
    @(posedge clk); #1;
    resp_ready = '0;

    // Randomized traffic against cycle-level model
    do_reset();
    begin
      int   phase, mk, mptr, w, c;
      res_t me;
      logic [N-1:0] er;
      phase = 0;
      mk = 0;
      mptr = 0;
      me = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(posedge clk); #1;
        req_valid = N'($urandom);
        resp_ready = N'($urandom);
        for (int k = 0; k < N; k++) begin
          if ($urandom_range(0, 7) == 0)
            c = $urandom_range(0, 15);
          else
            c = legal[$urandom_range(0, 5)];
          set_req(k, c, $urandom, $urandom);
        end
        @(negedge clk);
        er = '0;
        w = -1;
        if (phase == 0) begin
          for (int i = 0; i < N; i++) begin
            int j;
            j = (mptr + i) % N;
            if (w < 0 && req_valid[j]) w = j;
          end
          if (w >= 0) er = N'(1) << w;
        end
        chk("rnd_ready", req_ready, er);
        chk("rnd_busy", busy, phase != 0);
        chk("rnd_rv", resp_valid,
            (phase == 2) ? (N'(1) << mk) : N'(0));
        if (phase == 2) begin
          chk("rnd_o", resp_o, me.r);
          chk("rnd_flags",
              {resp_zero, resp_overflow,
               resp_exception, resp_error},
              {me.z, me.ov, me.ex, me.err});
        end
        if (phase == 0 && w >= 0) begin
          mk = w;
          me = ref_op(int'(req_ctrl[w*CW +: CW]),
                      req_i_1[w*DW +: DW],
                      req_i_2[w*DW +: DW]);
          mptr = (w + 1) % N;
          phase = 1;
        end else if (phase == 1) begin
          phase = 2;
        end else if (phase == 2 && resp_ready[mk]) begin
          phase = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
